// File: rtl/bmat_arbiter_pkg.sv
// Shared types and defaults for the bit-matrix unit arbiter slice.
// Imported by the arbiter top and its rotate-priority picker.
package bmat_arbiter_pkg;

    localparam int unsigned DEF_XLEN = 64;
    localparam int unsigned DEF_TAGW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Index width for an n-entry vector, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bmat_rr_pick.sv
// Rotate-priority picker: one-hot grant to the first valid index at or after ptr.
// Purely combinational so any shared-unit arbiter can reuse it.
module bmat_rr_pick
    import bmat_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_c
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && valid[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmat_arbiter.sv
// Round-robin arbiter sharing one multi-cycle bit-matrix unit between NREQ requesters,
// with a single operation in flight, owner-routed response and a completion watchdog.
module bmat_arbiter
    import bmat_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned TAGW    = DEF_TAGW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_xor,
    input  logic [NREQ*XLEN-1:0] req_rs1,
    input  logic [NREQ*XLEN-1:0] req_rs2,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_rd,
    output logic [TAGW-1:0]      rsp_tag,
    output logic                 rsp_err,
    output logic                 unit_start,
    output logic                 unit_xoren,
    output logic [XLEN-1:0]      unit_rs1,
    output logic [XLEN-1:0]      unit_rs2,
    input  logic [XLEN-1:0]      unit_rd,
    input  logic                 unit_busy,
    input  logic                 unit_done,
    output logic                 err_spurious
);

    localparam int unsigned PW = idx_width(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              xoren_q, xoren_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              err_q, err_d;
    logic              spur_q, spur_d;
    logic              start_q, start_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]   grant_c;
    logic [PW-1:0]     grant_idx_c;
    logic [TAGW-1:0]   sel_tag_c;
    logic              sel_xor_c;
    logic [XLEN-1:0]   sel_rs1_c;
    logic [XLEN-1:0]   sel_rs2_c;

    bmat_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .grant_c (grant_c)
    );

    // Accept only while idle and the unit is free; grant is already one-hot
    assign req_ready = (state_q == ST_IDLE && !unit_busy) ? grant_c : '0;

    // Steer the granted requester's payload
    always_comb begin
        grant_idx_c = '0;
        sel_tag_c   = '0;
        sel_xor_c   = 1'b0;
        sel_rs1_c   = '0;
        sel_rs2_c   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                grant_idx_c = PW'(i);
                sel_tag_c   = req_tag[i*TAGW +: TAGW];
                sel_xor_c   = req_xor[i];
                sel_rs1_c   = req_rs1[i*XLEN +: XLEN];
                sel_rs2_c   = req_rs2[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        tag_d       = tag_q;
        xoren_d     = xoren_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        start_d     = 1'b0;
        // A done strobe is only meaningful while an operation is running
        spur_d      = spur_q | (unit_done && state_q != ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    owner_d = grant_idx_c;
                    tag_d   = sel_tag_c;
                    xoren_d = sel_xor_c;
                    rs1_d   = sel_rs1_c;
                    rs2_d   = sel_rs2_c;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (unit_done) begin
                    rd_d        = unit_rd;
                    err_d       = 1'b0;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    state_d     = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rd_d        = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + PW'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            tag_q       <= '0;
            xoren_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            spur_q      <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            tag_q       <= tag_d;
            xoren_q     <= xoren_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            spur_q      <= spur_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rd       = rd_q;
    assign rsp_tag      = tag_q;
    assign rsp_err      = err_q;
    assign unit_start   = start_q;
    assign unit_xoren   = xoren_q;
    assign unit_rs1     = rs1_q;
    assign unit_rs2     = rs2_q;
    assign err_spurious = spur_q;

endmodule

// File: tb/tb_bmat_arbiter.sv
// Directed and randomized bench for bmat_arbiter with a behavioural bit-matrix unit
// (bmator / bmatxor) of configurable latency standing in for the real unit.
module tb_bmat_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned TAGW    = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned N_OPS   = 150;
    localparam logic [63:0] ANTI    = 64'h0102040810204080;
    localparam logic [63:0] IDENT   = 64'h8040201008040201;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready, req_xor;
    logic [NREQ*XLEN-1:0] req_rs1, req_rs2;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      rsp_valid, rsp_ready;
    logic [XLEN-1:0]      rsp_rd;
    logic [TAGW-1:0]      rsp_tag;
    logic                 rsp_err;
    logic                 unit_start, unit_xoren;
    logic [XLEN-1:0]      unit_rs1, unit_rs2;
    logic [XLEN-1:0]      unit_rd;
    logic                 unit_busy, unit_done;
    logic                 err_spurious;

    logic                 m_done, inj_done;
    bit                   stuck, rand_lat;
    int unsigned          lat, rem;

    int n_tests = 0;
    int n_fail  = 0;

    bmat_arbiter #(
        .NREQ    (NREQ),
        .XLEN    (XLEN),
        .TAGW    (TAGW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_xor      (req_xor),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd       (rsp_rd),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .unit_start   (unit_start),
        .unit_xoren   (unit_xoren),
        .unit_rs1     (unit_rs1),
        .unit_rs2     (unit_rs2),
        .unit_rd      (unit_rd),
        .unit_busy    (unit_busy),
        .unit_done    (unit_done),
        .err_spurious (err_spurious)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] flip8(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                y[8*c+r] = x[8*r+c];
        return y;
    endfunction

    function automatic logic [63:0] bmat_ref(input logic x, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] bt, y;
        logic [7:0]  v;
        bt = flip8(b);
        y  = '0;
        for (int i = 0; i < 64; i++) begin
            v    = a[8*(i/8) +: 8] & bt[8*(i%8) +: 8];
            y[i] = x ? ^v : |v;
        end
        return y;
    endfunction

    // Behavioural unit: busy from start until a one-cycle done strobe carrying the result
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            unit_busy <= 1'b0;
            m_done    <= 1'b0;
            unit_rd   <= '0;
            rem       <= 0;
        end else begin
            m_done  <= 1'b0;
            unit_rd <= '0;
            if (unit_start && !stuck) begin
                unit_busy <= 1'b1;
                rem       <= rand_lat ? $urandom_range(1, 6) : lat;
            end else if (rem != 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    m_done    <= 1'b1;
                    unit_busy <= 1'b0;
                    unit_rd   <= bmat_ref(unit_xoren, unit_rs1, unit_rs2);
                end
            end
        end
    end

    assign unit_done = m_done | inj_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int i, input logic x, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag);
        req_valid[i]             = 1'b1;
        req_xor[i]               = x;
        req_rs1[i*XLEN +: XLEN]  = a;
        req_rs2[i*XLEN +: XLEN]  = b;
        req_tag[i*TAGW +: TAGW]  = tag;
    endtask

    // Returns in the ISSUE cycle of requester i's accepted operation
    task automatic wait_grant(input int i, input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (req_ready[i]) got = 1'b1;
            tick();
        end
        req_valid[i] = 1'b0;
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic run_to_rsp(input int i, output int after_done, output int starts);
        int c;
        int dc;
        c      = 0;
        dc     = -1000;
        starts = 0;
        while (!rsp_valid[i] && c < 300) begin
            if (unit_done) dc = c;
            if (unit_start) starts++;
            tick();
            c++;
        end
        after_done = c - dc;
        check($sformatf("rsp%0d_seen", i), 64'(rsp_valid[i]), 64'd1);
    endtask

    initial begin
        int          ad, st, c, g0;
        bit          got, seen;
        logic [1:0]  g;
        int          issued, done_n;
        logic [63:0] exp_rd [2];
        logic [3:0]  exp_tag [2];
        bit          pend [2];
        bit          acc [2];
        logic [3:0]  next_tag;
        logic        rx;
        logic [63:0] ra, rb;

        reset     = 1'b1;
        req_valid = '0;
        req_xor   = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        rsp_ready = '0;
        inj_done  = 1'b0;
        stuck     = 1'b0;
        rand_lat  = 1'b0;
        lat       = 3;
        tick();
        tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        check("rst_unit_rs1", unit_rs1, 64'd0);
        check("rst_rsp_rd", rsp_rd, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_err_spurious", 64'(err_spurious), 64'd0);
        reset = 1'b0;
        tick();

        // Single request: anti-diagonal matrix times itself gives the identity
        send(0, 1'b0, ANTI, ANTI, 4'd5);
        #1;
        check("single_req_ready", 64'(req_ready), 64'b01);
        wait_grant(0, "single_grant");
        check("single_start", 64'(unit_start), 64'd1);
        check("single_unit_rs1", unit_rs1, ANTI);
        check("single_unit_xoren", 64'(unit_xoren), 64'd0);
        tick();
        check("single_start_pulse", 64'(unit_start), 64'd0);
        run_to_rsp(0, ad, st);
        check("single_rsp_latency", 64'(ad), 64'd1);
        check("single_extra_starts", 64'(st), 64'd0);
        check("single_rsp_valid", 64'(rsp_valid), 64'b01);
        check("single_rd", rsp_rd, IDENT);
        check("single_tag", 64'(rsp_tag), 64'd5);
        check("single_err", 64'(rsp_err), 64'd0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("single_rsp_drop", 64'(rsp_valid), 64'd0);

        // Identity as rs2 returns rs1 for both or and xor accumulate
        send(1, 1'b1, 64'hDEADBEEF01234567, IDENT, 4'd9);
        wait_grant(1, "ident_grant");
        run_to_rsp(1, ad, st);
        check("ident_rsp_valid", 64'(rsp_valid), 64'b10);
        check("ident_rd", rsp_rd, 64'hDEADBEEF01234567);
        check("ident_tag", 64'(rsp_tag), 64'd9);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Both requesters always valid: grants must alternate starting at requester 0
        send(0, 1'b0, ANTI, ANTI, 4'd1);
        send(1, 1'b1, IDENT, IDENT, 4'd2);
        rsp_ready = 2'b11;
        g0 = 0;
        for (int k = 0; k < 100; k++) begin
            got = 1'b0;
            g   = '0;
            for (int cc = 0; cc < 50 && !got; cc++) begin
                #1;
                if (req_ready != 2'b00) begin
                    got = 1'b1;
                    g   = req_ready;
                end
                tick();
            end
            if (g == 2'b01) g0++;
            check($sformatf("rr_grant_%0d", k), 64'(g), (k % 2 == 1) ? 64'b10 : 64'b01);
        end
        req_valid = '0;
        check("rr_fair_count", 64'(g0), 64'd50);
        run_to_rsp(1, ad, st);
        tick();
        rsp_ready = 2'b00;

        // Response backpressure with a competing request pending
        send(0, 1'b0, 64'h00FF00FF00FF00FF, IDENT, 4'd3);
        wait_grant(0, "bp_grant");
        send(1, 1'b0, 64'h1234567890ABCDEF, IDENT, 4'd4);
        run_to_rsp(0, ad, st);
        for (int j = 0; j < 10; j++) begin
            if (j == 3) rsp_ready = 2'b10;
            check("bp_rsp_valid", 64'(rsp_valid), 64'b01);
            check("bp_rd", rsp_rd, 64'h00FF00FF00FF00FF);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_no_start", 64'(unit_start), 64'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        check("bp_released", 64'(rsp_valid), 64'd0);
        check("bp_next_ready", 64'(req_ready), 64'b10);
        wait_grant(1, "bp_grant1");
        run_to_rsp(1, ad, st);
        check("bp_rd1", rsp_rd, 64'h1234567890ABCDEF);
        check("bp_tag1", 64'(rsp_tag), 64'd4);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Unit never completes: watchdog response, then a late done is flagged
        stuck = 1'b1;
        send(0, 1'b1, ANTI, IDENT, 4'd7);
        wait_grant(0, "to_grant");
        c = 0;
        while (!rsp_valid[0] && c < 200) begin
            tick();
            c++;
        end
        check("to_cycles", 64'(c), 64'(TIMEOUT + 1));
        check("to_err", 64'(rsp_err), 64'd1);
        check("to_rd", rsp_rd, 64'd0);
        check("to_tag", 64'(rsp_tag), 64'd7);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("to_no_spurious", 64'(err_spurious), 64'd0);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        check("late_done_spurious", 64'(err_spurious), 64'd1);
        tick();
        check("spurious_sticky", 64'(err_spurious), 64'd1);
        check("late_done_no_rsp", 64'(rsp_valid), 64'd0);
        stuck = 1'b0;

        // Reset while running drops the operation without a response
        lat = 20;
        send(1, 1'b1, ANTI, ANTI, 4'd6);
        wait_grant(1, "mid_grant");
        tick();
        tick();
        check("mid_running_rs1", unit_rs1, ANTI);
        reset = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_unit_rs1", unit_rs1, 64'd0);
        check("mid_rst_xoren", 64'(unit_xoren), 64'd0);
        check("mid_rst_tag", 64'(rsp_tag), 64'd0);
        check("mid_rst_spurious", 64'(err_spurious), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (rsp_valid != 2'b00) seen = 1'b1;
            tick();
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        lat = 3;
        send(0, 1'b0, ANTI, ANTI, 4'd12);
        wait_grant(0, "reissue_grant");
        run_to_rsp(0, ad, st);
        check("reissue_rd", rsp_rd, IDENT);
        check("reissue_tag", 64'(rsp_tag), 64'd12);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Random traffic with valid/ready gaps against the reference unit model
        rand_lat = 1'b1;
        issued   = 0;
        done_n   = 0;
        next_tag = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0;
            acc[i]  = 1'b0;
        end
        for (int cyc = 0; cyc < 20000 && !(issued >= int'(N_OPS) && done_n == issued); cyc++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || issued >= int'(N_OPS)) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    rx = 1'(($urandom_range(0, 1)));
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    send(i, rx, ra, rb, next_tag);
                    next_tag = next_tag + 4'd1;
                end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            for (int i = 0; i < 2; i++) begin
                acc[i] = req_valid[i] && req_ready[i];
                if (acc[i]) begin
                    exp_rd[i]  = bmat_ref(req_xor[i], req_rs1[i*XLEN +: XLEN], req_rs2[i*XLEN +: XLEN]);
                    exp_tag[i] = req_tag[i*TAGW +: TAGW];
                    pend[i]    = 1'b1;
                    issued++;
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    check($sformatf("rand_pending%0d", i), 64'(pend[i]), 64'd1);
                    check($sformatf("rand_rd%0d", i), rsp_rd, exp_rd[i]);
                    check($sformatf("rand_tag%0d", i), 64'(rsp_tag), 64'(exp_tag[i]));
                    pend[i] = 1'b0;
                    done_n++;
                end
            end
        end
        req_valid = '0;
        rsp_ready = '0;
        check("rand_issued", 64'(issued >= int'(N_OPS)), 64'd1);
        check("rand_all_returned", 64'(done_n), 64'(issued));
        check("rand_no_spurious", 64'(err_spurious), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
